fifo_serial_reader: RTL and testbench
=====================================

Name: fifo_serial_reader

Overview:
- Drains the byte FIFO from its read side: pops one entry at a time via `rd`/`empty`/`r_data` and transmits it as an asynchronous serial frame on `tx`.
- Frame format: 1 start bit (0), DATA_W data bits LSB-first, 1 stop bit (1).
- Sits between the FIFO read port and the serial output pin. It is the consumer counterpart to the FIFO write-side producer.

Parameters:
- DATA_W, 8, width of `r_data` and of the serial payload.
- CLKS_PER_BIT, 16, `clk` cycles per serial bit (≥2). Benches use 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- empty  input  1  FIFO empty flag.
- r_data  input  DATA_W  FIFO read data; valid in the cycle after the FIFO samples `rd`=1.
- rd  output  1  FIFO pop request, registered, single-cycle pulse.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  single-cycle pulse on the cycle after the stop bit completes.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, and overrides everything.
  - Reset values: `rd`=0, `tx`=1, `busy`=0, `frame_done`=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- State machine (registered): IDLE → FETCH → LATCH → START → DATA → STOP → IDLE.
- IDLE:
  - `tx`=1.
  - If `enable`=1 and `empty`=0 at an edge: `rd`<=1 and go to FETCH.
  - Otherwise stay in IDLE with `rd`=0.
- FETCH:
  - `rd` is high for exactly this one cycle; the FIFO samples it at the closing edge.
  - At that edge: `rd`<=0 and go to LATCH.
- LATCH:
  - `r_data` is valid during this cycle.
  - At the closing edge: capture `r_data` into the shift register, `tx`<=0, baud counter<=0, go to START.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles.
  - At the last cycle's edge: `tx`<=shift[0], bit counter<=0, go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At each bit boundary: shift right and output the next LSB.
  - After bit DATA_W-1 completes: `tx`<=1 and go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - At the closing edge: `frame_done`<=1 and go to IDLE.
  - `frame_done` is high for the first IDLE cycle only.
- Timing:
  - A frame is exactly 10·CLKS_PER_BIT cycles of `tx` when DATA_W=8, in general (DATA_W+2)·CLKS_PER_BIT.
  - Back-to-back frames have a minimum idle-high gap of 3 cycles (IDLE, FETCH, LATCH). The period is (DATA_W+2)·CLKS_PER_BIT+3 cycles.
  - Latency from `empty` falling (in IDLE with `enable`=1) to `tx` falling is 3 edges.
- Boundary conditions:
  - `rd` is never asserted while `empty`=1 is sampled in IDLE.
  - `rd` is never high for 2 consecutive cycles.
  - `rd` is never asserted outside FETCH.
  - `empty` and `r_data` are ignored in all states except IDLE (`empty`) and LATCH (`r_data`).
  - Deasserting `enable` mid-frame does not abort the frame. The block returns to IDLE and stays there.
  - `empty` rising after the pop does not affect the frame in progress.
  - Reset mid-frame: at the next edge `tx`=1, `rd`=0, `busy`=0, state IDLE. The popped byte is discarded and not retransmitted.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT) and wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width is clog2(DATA_W).
  - No other arithmetic.

Test Plan:
- Reset check: hold `reset` for 6 cycles with `empty`=0 and `enable`=1 → `tx`=1, `rd`=0, `busy`=0, `frame_done`=0 throughout. The first `rd` pulse occurs on the edge after `reset` falls.
- Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, `enable`=1.
  - Expect one `rd` pulse, 1 cycle wide.
  - `tx` sequence, 4 cycles per bit: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop).
  - Then one `frame_done` pulse, and `busy` low after 40 `tx` cycles.
- Back-to-back: FIFO holds 0x01,0x02,0x03 → three frames.
  - Start bits are spaced 43 cycles apart.
  - Exactly 3 `rd` pulses, then `empty`=1 and the block stays in IDLE with no further `rd`.
- Empty/enable gating:
  - `empty`=1 with `enable`=1 for 50 cycles → no `rd`, `tx`=1.
  - `empty`=0 with `enable`=0 → no `rd`.
  - Raising `enable` → `rd` pulse on the next edge.
- Mid-frame controls:
  - Drop `enable` during DATA of byte 0x3C with the FIFO non-empty → the 0x3C frame completes, then no further `rd`.
  - Assert `reset` during DATA → next-edge `tx`=1, `busy`=0. After release, the next FIFO byte (not 0x3C) is transmitted.
- FIFO integration: connect to the FIFO, write 0x1..0xA until full, then enable → a serial decode of `tx` yields the stored bytes in order with no duplicates or drops. `rd` is never asserted while `empty`=1.

Source files
------------

// File: rtl/fifo_serial_reader_if.sv
// fifo_serial_reader_if
//   Groups the FIFO read-side handshake and the serial output of the
//   FIFO serial reader into one bundle.
//   enable     : permits starting a new frame
//   empty      : FIFO empty flag
//   r_data     : FIFO read data, valid the cycle after a pop
//   rd         : FIFO pop request, single-cycle pulse
//   tx         : serial line, idles high
//   busy       : reader is not idle
//   frame_done : single-cycle pulse after the stop bit
//   master = the reader, slave = the FIFO/pin side.
interface fifo_serial_reader_if #(
   parameter int DATA_W = 8
);
   logic              enable;
   logic              empty;
   logic [DATA_W-1:0] r_data;
   logic              rd;
   logic              tx;
   logic              busy;
   logic              frame_done;

   modport master (
      input  enable, empty, r_data,
      output rd, tx, busy, frame_done
   );

   modport slave (
      output enable, empty, r_data,
      input  rd, tx, busy, frame_done
   );
endinterface

// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader
//   Pops bytes from a FIFO one at a time and sends each as an async serial
//   frame: start bit (0), DATA_W data bits LSB first, stop bit (1).
//   clk_i   : system clock, rising edge
//   reset_i : synchronous, active-high reset
//   bus     : fifo_serial_reader_if.master (enable, empty, r_data in;
//             rd, tx, busy, frame_done out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line high, wait for enable && !empty, then issue rd
//   FETCH   | rd high for this single cycle, FIFO pops at closing edge
//   LATCH   | r_data valid, captured into shift register, start bit next
//   START   | start bit (low) for CLKS_PER_BIT cycles
//   DATA    | DATA_W data bits, CLKS_PER_BIT cycles each, LSB first
//   STOP    | stop bit (high), frame_done pulses in the next IDLE cycle
module fifo_serial_reader #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   fifo_serial_reader_if.master bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              rd_q, rd_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;

   logic              baud_tc;
   logic              bit_last;
   logic [DATA_W-1:0] shift_nx;

   // Baud timer counts down from CLKS_PER_BIT-1; terminal count marks the
   // last cycle of the current bit.
   assign baud_tc  = (baud_q == '0);
   assign bit_last = (bit_q == BIT_LAST);
   assign shift_nx = shift_q >> 1;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rd_q    <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable && !bus.empty) state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: begin
            shift_d = bus.r_data;
            baud_d  = BAUD_LOAD;
            state_d = ST_START;
         end
         ST_START: begin
            if (baud_tc) begin
               baud_d  = BAUD_LOAD;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (baud_tc) begin
               baud_d = BAUD_LOAD;
               if (bit_last) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + BIT_ONE;
                  shift_d = shift_nx;
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (baud_tc) state_d = ST_IDLE;
            else         baud_d  = baud_q - BAUD_ONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered: the _d values here land on the pins one edge
   // later, which is why the start bit is launched from LATCH.
   always_comb begin
      rd_d   = 1'b0;
      tx_d   = tx_q;
      done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            rd_d = bus.enable && !bus.empty;
         end
         ST_FETCH: tx_d = 1'b1;
         ST_LATCH: tx_d = 1'b0;
         ST_START: begin
            if (baud_tc) tx_d = shift_q[0];
         end
         ST_DATA: begin
            if (baud_tc) tx_d = bit_last ? 1'b1 : shift_nx[0];
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_tc) done_d = 1'b1;
         end
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.rd         = rd_q;
   assign bus.tx         = tx_q;
   assign bus.frame_done = done_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_serial_reader.sv
// tb_fifo_serial_reader
//   Drives the FIFO serial reader from a small FIFO model. Bytes written to
//   the FIFO are queued as expected frames; a monitor decodes tx serially
//   and compares each frame against the queue.
module tb_fifo_serial_reader;

   localparam int DW     = 8;
   localparam int C      = 4;
   localparam int FRAME  = (DW + 2) * C;
   localparam int PERIOD = FRAME + 3;
   localparam int DEPTH  = 10;

   logic clk_i = 1'b0;
   logic reset_i;

   fifo_serial_reader_if #(.DATA_W(DW)) bus ();

   fifo_serial_reader #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int rd_pulses = 0;
   int rd_empty_viol = 0;
   int rd_dbl_viol = 0;
   int frames_started = 0;
   int frames_done = 0;
   int glitches = 0;
   logic [7:0] sb[$];
   int start_times[$];

   // FIFO model
   logic [7:0] fmem[DEPTH];
   int   fhead = 0;
   int   ftail = 0;
   int   fcount = 0;
   logic wr_en;
   logic [7:0] wr_data;
   bit   do_rd, do_wr, rd_prev = 1'b0;

   assign bus.empty = (fcount == 0);

   always @(posedge clk_i) begin
      cyc++;
      if (bus.rd === 1'b1) rd_pulses++;
      if (bus.rd === 1'b1 && fcount == 0) rd_empty_viol++;
      if (bus.rd === 1'b1 && rd_prev) rd_dbl_viol++;
      rd_prev = (bus.rd === 1'b1);
      do_rd = (bus.rd === 1'b1) && (fcount != 0);
      do_wr = wr_en && (fcount != DEPTH);
      if (do_rd) begin
         bus.r_data <= fmem[fhead];
         fhead <= (fhead + 1) % DEPTH;
      end
      if (do_wr) begin
         fmem[ftail] <= wr_data;
         ftail <= (ftail + 1) % DEPTH;
      end
      fcount <= fcount + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      while (fcount >= DEPTH && n < 2000) begin
         tick(1);
         n++;
      end
      wr_data = b;
      wr_en   = 1'b1;
      sb.push_back(b);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         tick(1);
         n++;
      end
      check("frame_wait", 32'(frames_done >= target), 1);
   endtask

   task automatic wait_start(input int target, input int budget);
      int n = 0;
      while (frames_started < target && n < budget) begin
         tick(1);
         n++;
      end
      check("start_wait", 32'(frames_started >= target), 1);
   endtask

   // Serial decoder / scoreboard consumer
   initial begin : monitor
      logic [DW+1:0] bits;
      logic bitv, fd_m1, fd0, busy0;
      logic [7:0] exp_b;
      int idx;
      bit in_frame;
      in_frame = 1'b0;
      idx = 0;
      bitv = 1'b1;
      fd_m1 = 1'b0;
      fd0 = 1'b0;
      busy0 = 1'b0;
      bits = '0;
      forever begin
         @(negedge clk_i);
         if (reset_i !== 1'b0) begin
            in_frame = 1'b0;
            continue;
         end
         if (!in_frame) begin
            if (bus.tx !== 1'b0) continue;
            in_frame = 1'b1;
            idx = 0;
            frames_started++;
            start_times.push_back(cyc);
         end
         if (idx < FRAME) begin
            if (idx % C == 0) begin
               bitv = bus.tx;
               bits[idx / C] = bus.tx;
            end else if (bus.tx !== bitv) begin
               glitches++;
            end
            if (idx == FRAME - 1) fd_m1 = bus.frame_done;
         end else if (idx == FRAME) begin
            fd0   = bus.frame_done;
            busy0 = bus.busy;
         end else begin
            check("frame_done_busy", {fd_m1, fd0, busy0, bus.frame_done}, 4'b0100);
            check("framing_start_stop", {bits[DW+1], bits[0]}, 2'b10);
            check("frame_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_b = sb.pop_front();
               check("frame_data", bits[DW:1], exp_b);
            end
            frames_done++;
            in_frame = 1'b0;
         end
         idx++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r0, st0, fd, fs, lows;
      logic [7:0] rb;
      reset_i    = 1'b1;
      bus.enable = 1'b1;
      wr_en      = 1'b0;
      wr_data    = '0;

      // reset held with data available and enable high
      tick(1);
      push(8'hA5);
      for (int i = 0; i < 6; i++) begin
         check("reset_outputs", {bus.tx, bus.rd, bus.busy, bus.frame_done}, 4'b1000);
         tick(1);
      end
      r0 = rd_pulses;
      reset_i = 1'b0;
      tick(1);
      check("first_rd_after_reset", bus.rd, 1);

      // single byte
      wait_frames(1, 200);
      tick(5);
      check("single_rd_count", rd_pulses - r0, 1);
      check("single_busy_low", bus.busy, 0);

      // back-to-back
      r0  = rd_pulses;
      st0 = start_times.size();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      wait_frames(4, 3 * PERIOD + 60);
      if (start_times.size() >= st0 + 3) begin
         check("b2b_spacing_0", start_times[st0+1] - start_times[st0], PERIOD);
         check("b2b_spacing_1", start_times[st0+2] - start_times[st0+1], PERIOD);
      end else begin
         check("b2b_start_count", start_times.size() - st0, 3);
      end
      tick(60);
      check("b2b_rd_count", rd_pulses - r0, 3);
      check("b2b_idle", bus.busy, 0);

      // empty / enable gating
      r0 = rd_pulses;
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.tx !== 1'b1) lows++;
         tick(1);
      end
      check("empty_no_rd", rd_pulses - r0, 0);
      check("empty_tx_high", lows, 0);
      bus.enable = 1'b0;
      push(8'h5A);
      tick(20);
      check("disabled_no_rd", rd_pulses - r0, 0);
      bus.enable = 1'b1;
      tick(1);
      check("enable_rd_next_edge", bus.rd, 1);
      tick(1);
      check("latency_tx_still_high", bus.tx, 1);
      tick(1);
      check("latency_tx_low_3_edges", bus.tx, 0);
      wait_frames(5, PERIOD + 20);

      // randomized traffic with enable toggling
      for (int i = 0; i < 12; i++) begin
         rb = 8'($urandom_range(255));
         push(rb);
         bus.enable = ($urandom_range(3) != 0);
         tick($urandom_range(60));
      end
      bus.enable = 1'b1;
      wait_frames(17, 14 * PERIOD + 200);

      // drop enable mid-frame
      fd = frames_done;
      fs = frames_started;
      tick(5);
      r0 = rd_pulses;
      push(8'h3C);
      push(8'h11);
      push(8'h22);
      wait_start(fs + 1, 50);
      tick(2 * C);
      bus.enable = 1'b0;
      wait_frames(fd + 1, FRAME + 20);
      tick(60);
      check("enable_drop_rd_count", rd_pulses - r0, 1);
      check("enable_drop_idle", bus.busy, 0);

      // reset mid-frame
      fs = frames_started;
      bus.enable = 1'b1;
      wait_start(fs + 1, 50);
      tick(3 * C);
      reset_i = 1'b1;
      void'(sb.pop_front());
      tick(1);
      check("reset_midframe", {bus.tx, bus.busy, bus.rd}, 3'b100);
      tick(1);
      reset_i = 1'b0;
      wait_frames(fd + 2, PERIOD + 40);

      // fill FIFO then drain
      bus.enable = 1'b0;
      tick(5);
      r0 = rd_pulses;
      fd = frames_done;
      for (int v = 1; v <= 10; v++) push(8'(v));
      check("fifo_full", fcount, DEPTH);
      bus.enable = 1'b1;
      wait_frames(fd + 10, 10 * PERIOD + 100);
      tick(10);
      check("integ_rd_count", rd_pulses - r0, 10);

      check("scoreboard_drained", sb.size(), 0);
      check("rd_while_empty", rd_empty_viol, 0);
      check("rd_two_cycles", rd_dbl_viol, 0);
      check("tx_bit_stability", glitches, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
